seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans a 32-bit word as 8 hex digits on a shared 7-segment bus, frame-aligned double buffering.
// Latency: AN/SEG registered one cycle behind idx/disp; a load reaches the display at the next frame boundary.
// Backpressure: none; load is always accepted, later loads before the boundary replace the staged word.
// Optional SEG_LZB_EN: blank leading-zero digits above digit 0.
module seg7_scan_driver #(
    parameter int DIV_COUNT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        load,
    output logic        pending,
    output logic        upd_ack,
    output logic [7:0]  AN,
    output logic [7:0]  SEG
);

    localparam logic [23:0] DIV_LAST = 24'(DIV_COUNT - 1);

    logic [23:0] prescaler;
    logic [2:0]  idx;
    logic [31:0] staging;
    logic [31:0] disp;
    logic        tick;
    logic        fb;
    logic [3:0]  nibble;
    logic        blank;
    logic [7:0]  an_nxt;
    logic [7:0]  seg_nxt;

    function automatic logic [7:0] hex_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick   = (prescaler == DIV_LAST);
    assign fb     = tick && (idx == 3'd7);
    assign nibble = disp[{idx, 2'b00} +: 4];

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    assign blank = (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 32'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_nxt  = ~(8'b1 << idx);
        seg_nxt = hex_decode(nibble);
        if (blank) begin
            an_nxt  = 8'hFF;
            seg_nxt = 8'hFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= 24'd0;
            idx       <= 3'd0;
            staging   <= 32'd0;
            disp      <= 32'd0;
            pending   <= 1'b0;
            upd_ack   <= 1'b0;
            AN        <= 8'hFF;
            SEG       <= 8'hFF;
        end else begin
            upd_ack <= 1'b0;
            if (tick) begin
                prescaler <= 24'd0;
                idx       <= idx + 3'd1;
            end else begin
                prescaler <= prescaler + 24'd1;
            end

            // A load landing on the boundary bypasses staging so it is never a frame late.
            if (fb) begin
                if (load) begin
                    disp    <= value;
                    staging <= value;
                    pending <= 1'b0;
                    upd_ack <= 1'b1;
                end else if (pending) begin
                    disp    <= staging;
                    pending <= 1'b0;
                    upd_ack <= 1'b1;
                end
            end else if (load) begin
                staging <= value;
                pending <= 1'b1;
            end

            AN  <= an_nxt;
            SEG <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIV_COUNT=4; commits are queued at load time and checked per displayed frame.
module tb_seg7_scan_driver;

    localparam int DIV = 4;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic        load;
    logic        pending;
    logic        upd_ack;
    logic [7:0]  AN;
    logic [7:0]  SEG;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] cur_disp;

    seg7_scan_driver #(.DIV_COUNT(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .pending (pending),
        .upd_ack (upd_ack),
        .AN      (AN),
        .SEG     (SEG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_an(input logic [31:0] w, input int i);
`ifdef SEG_LZB_EN
        if (i > 0 && (w >> (4 * i)) == 32'd0) return 8'hFF;
`endif
        return ~(8'h01 << i);
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] w, input int i);
        logic [3:0] nib;
`ifdef SEG_LZB_EN
        if (i > 0 && (w >> (4 * i)) == 32'd0) return 8'hFF;
`endif
        nib = w[4 * i +: 4];
        return SEG_TAB[nib];
    endfunction

    // Called on the first cycle of a digit-0 slot; checks all 8 slots and the wrap.
    task automatic check_frame(input logic [31:0] w, input string name);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_an%0d", name, i), {24'd0, AN}, {24'd0, exp_an(w, i)});
            chk($sformatf("%s_seg%0d", name, i), {24'd0, SEG}, {24'd0, exp_seg(w, i)});
            repeat (DIV) @(negedge clk);
        end
        chk($sformatf("%s_wrap", name), {24'd0, AN}, {24'd0, exp_an(w, 0)});
    endtask

    // Returns on the first cycle at which AN turns to digit 0.
    task automatic sync_frame();
        logic [7:0] prev;
        bit found;
        found = 0;
        prev = AN;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (AN == 8'hFE && prev != 8'hFE) begin
                found = 1;
                break;
            end
            prev = AN;
        end
        if (!found) chk("sync_timeout", 0, 1);
    endtask

    task automatic pulse_load(input logic [31:0] v, input bit fresh);
        if (fresh || exp_q.size() == 0) exp_q.push_back(v);
        else exp_q[exp_q.size() - 1] = v;
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic expect_commit(input string name);
        bit found;
        logic [31:0] w;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (upd_ack) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            chk({name, "_ack_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            chk({name, "_unexpected_ack"}, 1, 0);
        end else begin
            w = exp_q.pop_front();
            chk({name, "_pending_clr"}, {31'd0, pending}, 0);
            @(negedge clk);
            chk({name, "_ack_pulse"}, {31'd0, upd_ack}, 0);
            check_frame(w, name);
            cur_disp = w;
        end
    endtask

    initial begin
        int acks;
        n_tests  = 0;
        n_fail   = 0;
        cur_disp = 32'd0;
        rst   = 1'b0;
        load  = 1'b0;
        value = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_an", {24'd0, AN}, 32'hFF);
        chk("rst_seg", {24'd0, SEG}, 32'hFF);
        chk("rst_pending", {31'd0, pending}, 0);
        chk("rst_ack", {31'd0, upd_ack}, 0);

        rst = 1'b1;
        @(negedge clk);
        check_frame(32'd0, "scan0");

        // Load mid-frame at digit 2, held until the boundary.
        sync_frame();
        repeat (9) @(negedge clk);
        pulse_load(32'h1234ABCD, 1);
        chk("ld1_pending", {31'd0, pending}, 1);
        repeat (7) @(negedge clk);
        chk("ld1_hold_an", {24'd0, AN}, {24'd0, exp_an(cur_disp, 4)});
        chk("ld1_hold_seg", {24'd0, SEG}, {24'd0, exp_seg(cur_disp, 4)});
        expect_commit("ld1");

        // Two loads in one frame: last wins, one ack.
        sync_frame();
        repeat (5) @(negedge clk);
        pulse_load(32'h11111111, 1);
        repeat (5) @(negedge clk);
        pulse_load(32'h22222222, 0);
        chk("ld2_pending", {31'd0, pending}, 1);
        expect_commit("ld2");
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (upd_ack) acks++;
        end
        chk("ld2_no_extra_ack", acks, 0);

        // Load on the boundary cycle while another word is pending.
        sync_frame();
        repeat (3) @(negedge clk);
        pulse_load(32'h55555555, 1);
        chk("fbld_pending", {31'd0, pending}, 1);
        repeat (26) @(negedge clk);
        pulse_load(32'hFFFFFFFF, 0);
        chk("fbld_ack_now", {31'd0, upd_ack}, 1);
        expect_commit("fbld");

        // Reset mid-digit with a staged word.
        sync_frame();
        repeat (3) @(negedge clk);
        pulse_load(32'h89ABCDEF, 1);
        chk("rst2_pending_pre", {31'd0, pending}, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst2_an", {24'd0, AN}, 32'hFF);
        chk("rst2_seg", {24'd0, SEG}, 32'hFF);
        chk("rst2_pending", {31'd0, pending}, 0);
        void'(exp_q.pop_back());
        cur_disp = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst2_hold_an", {24'd0, AN}, 32'hFF);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_rel_pending", {31'd0, pending}, 0);
        check_frame(32'd0, "rst2_scan");

`ifdef SEG_LZB_EN
        sync_frame();
        repeat (3) @(negedge clk);
        pulse_load(32'h000000A5, 1);
        expect_commit("lzb_a5");
        sync_frame();
        repeat (3) @(negedge clk);
        pulse_load(32'h00000000, 1);
        expect_commit("lzb_zero");
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
